// File: rtl/mfp_pkg.sv
// ============================================================================
// mfp_pkg : shared constants and types for the MFP68901 interrupt controller
// Rev 1.0
// ============================================================================
`default_nettype none

package mfp_pkg;

  localparam logic [4:0] ADDR_IERA = 5'h03;
  localparam logic [4:0] ADDR_IERB = 5'h04;
  localparam logic [4:0] ADDR_IPRA = 5'h05;
  localparam logic [4:0] ADDR_IPRB = 5'h06;
  localparam logic [4:0] ADDR_ISRA = 5'h07;
  localparam logic [4:0] ADDR_ISRB = 5'h08;
  localparam logic [4:0] ADDR_IMRA = 5'h09;
  localparam logic [4:0] ADDR_IMRB = 5'h0A;
  localparam logic [4:0] ADDR_VR   = 5'h0B;

  localparam int CH_GPIP0   = 0;
  localparam int CH_GPIP1   = 1;
  localparam int CH_GPIP2   = 2;
  localparam int CH_GPIP3   = 3;
  localparam int CH_TIMER_D = 4;
  localparam int CH_TIMER_C = 5;
  localparam int CH_GPIP4   = 6;
  localparam int CH_GPIP5   = 7;
  localparam int CH_TIMER_B = 8;
  localparam int CH_USART0  = 9;
  localparam int CH_USART1  = 10;
  localparam int CH_USART2  = 11;
  localparam int CH_USART3  = 12;
  localparam int CH_TIMER_A = 13;
  localparam int CH_GPIP6   = 14;
  localparam int CH_GPIP7   = 15;

  localparam logic [7:0] SPURIOUS_VEC = 8'h18;

  typedef enum logic [1:0] {
    IACK_IDLE = 2'd0,
    IACK_ACK  = 2'd1,
    IACK_HOLD = 2'd2
  } iack_state_e;

endpackage

`default_nettype wire

// File: rtl/mfp_prio_enc.sv
// ============================================================================
// mfp_prio_enc : 16-bit highest-set-bit encoder (bit 15 wins)
// Rev 1.0
// ============================================================================
`default_nettype none

module mfp_prio_enc (
  input  logic [15:0] req,
  output logic [3:0]  idx,
  output logic        vld
);

  always_comb begin
    idx = 4'd0;
    vld = |req;
    for (int i = 0; i < 16; i++) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mfp_irq_ctrl.sv
// ============================================================================
// mfp_irq_ctrl : MFP68901 interrupt controller (IER/IPR/ISR/IMR/VR, IACK FSM)
// Rev 1.0
// ============================================================================
`default_nettype none

module mfp_irq_ctrl
  import mfp_pkg::*;
#(
  parameter logic [7:0] VR_RESET = 8'h00,
  parameter int         IRQ_REG  = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  ADDR,
  input  logic        DAT_WE,
  input  logic [7:0]  DAT_I,
  output logic [7:0]  DAT_O,
  input  logic [15:0] EVT,
  input  logic        IACK,
  output logic [7:0]  VEC,
  output logic        VEC_VALID,
  output logic        IRQ_N
);

  logic [15:0] ier_q, ier_d, ipr_q, ipr_d, isr_q, isr_d, imr_q, imr_d;
  logic [7:0]  vr_q, vr_d, dat_o_q, dat_o_d, vec_q, vec_d;
  logic        vec_valid_q, vec_valid_d, iack_q, irq_n_d;
  iack_state_e state_q, state_d;

  logic [15:0] evt_set, above, ack_elig, irq_elig;
  logic [3:0]  isr_idx, ack_idx;
  logic        isr_vld, ack_vld, take;

  mfp_prio_enc u_isr_enc (.req(isr_q),    .idx(isr_idx), .vld(isr_vld));
  mfp_prio_enc u_ack_enc (.req(ack_elig), .idx(ack_idx), .vld(ack_vld));

  // Acknowledge selection sees same-cycle events; the request line only sees latched state.
  always_comb begin
    evt_set = EVT & ier_q;
    for (int i = 0; i < 16; i++) begin
      above[i] = !isr_vld || (4'(i) > isr_idx);
    end
    ack_elig = (ipr_q | evt_set) & imr_q & above;
    irq_elig = ipr_q & imr_q & above;
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    take        = 1'b0;
    case (state_q)
      IACK_IDLE: if (IACK && !iack_q) state_d = IACK_ACK;
      IACK_ACK: begin
        vec_valid_d = 1'b1;
        state_d     = IACK_HOLD;
        if (ack_vld) begin
          vec_d = {vr_q[7:4], ack_idx};
          take  = 1'b1;
        end else begin
          vec_d = SPURIOUS_VEC;
        end
      end
      IACK_HOLD: if (!IACK) begin
        vec_valid_d = 1'b0;
        state_d     = IACK_IDLE;
      end
      default: state_d = IACK_IDLE;
    endcase
  end

  always_comb begin
    ier_d = ier_q;
    ipr_d = ipr_q;
    isr_d = isr_q;
    imr_d = imr_q;
    vr_d  = vr_q;
    if (DAT_WE) begin
      case (ADDR)
        ADDR_IERA: ier_d[15:8] = DAT_I;
        ADDR_IERB: ier_d[7:0]  = DAT_I;
        ADDR_IPRA: ipr_d[15:8] = ipr_q[15:8] & DAT_I;
        ADDR_IPRB: ipr_d[7:0]  = ipr_q[7:0] & DAT_I;
        ADDR_ISRA: isr_d[15:8] = isr_q[15:8] & DAT_I;
        ADDR_ISRB: isr_d[7:0]  = isr_q[7:0] & DAT_I;
        ADDR_IMRA: imr_d[15:8] = DAT_I;
        ADDR_IMRB: imr_d[7:0]  = DAT_I;
        ADDR_VR: begin
          vr_d = DAT_I;
          if (!DAT_I[3]) isr_d = '0;
        end
        default: ;
      endcase
    end
    if (take) begin
      ipr_d[ack_idx] = 1'b0;
      if (vr_q[3]) isr_d[ack_idx] = 1'b1;
    end
    // A new event beats any clear in the same cycle; disabling a channel drops its pending bit.
    ipr_d = (ipr_d | evt_set) & ier_d;
  end

  always_comb begin
    case (ADDR)
      ADDR_IERA: dat_o_d = ier_q[15:8];
      ADDR_IERB: dat_o_d = ier_q[7:0];
      ADDR_IPRA: dat_o_d = ipr_q[15:8];
      ADDR_IPRB: dat_o_d = ipr_q[7:0];
      ADDR_ISRA: dat_o_d = isr_q[15:8];
      ADDR_ISRB: dat_o_d = isr_q[7:0];
      ADDR_IMRA: dat_o_d = imr_q[15:8];
      ADDR_IMRB: dat_o_d = imr_q[7:0];
      ADDR_VR:   dat_o_d = vr_q;
      default:   dat_o_d = 8'h00;
    endcase
    irq_n_d = !((|irq_elig) && (state_d == IACK_IDLE));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ier_q       <= '0;
      ipr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      vr_q        <= VR_RESET;
      dat_o_q     <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      iack_q      <= 1'b0;
      state_q     <= IACK_IDLE;
    end else begin
      ier_q       <= ier_d;
      ipr_q       <= ipr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      vr_q        <= vr_d;
      dat_o_q     <= dat_o_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      iack_q      <= IACK;
      state_q     <= state_d;
    end
  end

  generate
    if (IRQ_REG != 0) begin : g_irq_reg
      logic irq_n_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) irq_n_q <= 1'b1;
        else        irq_n_q <= irq_n_d;
      end
      assign IRQ_N = irq_n_q;
    end else begin : g_irq_comb
      assign IRQ_N = !((|irq_elig) && (state_q == IACK_IDLE));
    end
  endgenerate

  assign DAT_O     = dat_o_q;
  assign VEC       = vec_q;
  assign VEC_VALID = vec_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mfp_irq_ctrl.sv
// ============================================================================
// tb_mfp_irq_ctrl : directed self-checking bench for mfp_irq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mfp_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  addr = '0;
  logic        dat_we = 1'b0;
  logic [7:0]  dat_i = '0;
  logic [7:0]  dat_o;
  logic [15:0] evt = '0;
  logic        iack = 1'b0;
  logic [7:0]  vec;
  logic        vec_valid;
  logic        irq_n;
  logic [7:0]  rdv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mfp_irq_ctrl #(.VR_RESET(8'h40), .IRQ_REG(1)) dut (
    .CLK(clk), .RST_N(rst_n), .ADDR(addr), .DAT_WE(dat_we), .DAT_I(dat_i),
    .DAT_O(dat_o), .EVT(evt), .IACK(iack), .VEC(vec), .VEC_VALID(vec_valid),
    .IRQ_N(irq_n)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    addr = a; dat_we = 1'b1; dat_i = d;
    @(negedge clk);
    dat_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    addr = a;
    @(negedge clk);
    d = dat_o;
  endtask

  task automatic pulse(input logic [15:0] e);
    evt = e;
    @(negedge clk);
    evt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_dat_o", dat_o, 0);
    chk("rst_vec", vec, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_irq_n", irq_n, 1);
    rst_n = 1'b1;
    tick();
    rd(5'h0B, rdv); chk("rst_vr", rdv, 8'h40);

    // 1: Timer A event latches and raises the request
    wr(5'h03, 8'h20);
    wr(5'h09, 8'h20);
    pulse(16'h2000);
    chk("t1_irq_latency", irq_n, 1);
    rd(5'h05, rdv); chk("t1_ipra", rdv, 8'h20);
    chk("t1_irq_low", irq_n, 0);

    // 2: acknowledge in software-EOI mode
    wr(5'h0B, 8'h48);
    iack = 1'b1;
    tick();
    chk("t2_vv_early", vec_valid, 0);
    tick();
    chk("t2_vec", vec, 8'h4D);
    chk("t2_vv", vec_valid, 1);
    chk("t2_irq_n", irq_n, 1);
    rd(5'h05, rdv); chk("t2_ipra", rdv, 8'h00);
    rd(5'h07, rdv); chk("t2_isra", rdv, 8'h20);
    chk("t2_vv_held", vec_valid, 1);
    iack = 1'b0;
    tick();
    chk("t2_vv_drop", vec_valid, 0);
    rd(5'h0C, rdv); chk("t2_unmapped", rdv, 8'h00);

    // 3: in-service Timer A blocks lower-priority Timer B
    wr(5'h03, 8'h21);
    wr(5'h09, 8'h21);
    pulse(16'h0100);
    tick();
    chk("t3_irq_blocked", irq_n, 1);
    rd(5'h05, rdv); chk("t3_ipra", rdv, 8'h01);
    wr(5'h07, 8'hDF);
    tick();
    chk("t3_irq_unblocked", irq_n, 0);
    iack = 1'b1;
    tick(); tick();
    chk("t3_vec", vec, 8'h48);
    iack = 1'b0;
    tick();
    rd(5'h07, rdv); chk("t3_isra", rdv, 8'h01);
    wr(5'h07, 8'h00);

    // 4: masking and IER clear
    wr(5'h04, 8'h20);
    pulse(16'h0020);
    tick();
    rd(5'h06, rdv); chk("t4_iprb", rdv, 8'h20);
    chk("t4_irq_masked", irq_n, 1);
    wr(5'h0A, 8'h20);
    tick();
    chk("t4_irq_unmasked", irq_n, 0);
    wr(5'h04, 8'h00);
    rd(5'h06, rdv); chk("t4_iprb_cleared", rdv, 8'h00);
    chk("t4_irq_off", irq_n, 1);

    // 5: event set wins over same-cycle IPR clear; plain clear works
    wr(5'h04, 8'h10);
    evt = 16'h0010; addr = 5'h06; dat_we = 1'b1; dat_i = 8'hEF;
    tick();
    evt = '0; dat_we = 1'b0;
    rd(5'h06, rdv); chk("t5_set_wins", rdv, 8'h10);
    wr(5'h06, 8'hEF);
    rd(5'h06, rdv); chk("t5_and_clear", rdv, 8'h00);
    pulse(16'h0010);
    rd(5'h06, rdv); chk("t5_repend", rdv, 8'h10);
    chk("t5_irq_masked", irq_n, 1);

    // 6: spurious acknowledge, then reset during HOLD
    iack = 1'b1;
    tick(); tick();
    chk("t6_vec_spur", vec, 8'h18);
    chk("t6_vv", vec_valid, 1);
    rd(5'h06, rdv); chk("t6_iprb", rdv, 8'h10);
    rd(5'h07, rdv); chk("t6_isra", rdv, 8'h00);
    rd(5'h08, rdv); chk("t6_isrb", rdv, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vv", vec_valid, 0);
    chk("t6_rst_vec", vec, 0);
    chk("t6_rst_irq", irq_n, 1);
    iack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
